// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline control unit: opcodes, ALU commands, immediate
// and ALU-control selects, condition codes, flag bit positions and stage control records.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_DP   = 2'b00,
        OP_MEM  = 2'b01,
        OP_BR   = 2'b10,
        OP_NONE = 2'b11
    } op_e;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [1:0] IMM_ROT8 = 2'b00;
    localparam logic [1:0] IMM_12   = 2'b01;
    localparam logic [1:0] IMM_24   = 2'b10;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Control carried from Decode into Execute.
    typedef struct packed {
        logic       reg_w;
        logic       mem_w;
        logic       mem_to_reg;
        logic       branch;
        logic       alu_src;
        logic [1:0] alu_ctrl;
        logic [1:0] flag_w;
        logic       pc_src;
        logic [3:0] cond;
    } ctrl_e_t;

    // Control carried through Memory and Writeback, already condition-gated.
    typedef struct packed {
        logic reg_w;
        logic mem_w;
        logic mem_to_reg;
        logic pc_src;
    } ctrl_mw_t;

endpackage

// File: rtl/pipe_controller_cond_unit.sv
// NZCV flags register and ARM condition evaluation for the instruction in Execute.
// Flag writes are suppressed when the instruction fails its condition.
module cond_unit
    import pipe_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic [1:0] flag_w,
    output logic       cond_ex
);

    logic [3:0] flags;
    logic       n_f, z_f, c_f, v_f;

    assign n_f = flags[FLAG_N];
    assign z_f = flags[FLAG_Z];
    assign c_f = flags[FLAG_C];
    assign v_f = flags[FLAG_V];

    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            COND_EQ: cond_ex = z_f;
            COND_NE: cond_ex = ~z_f;
            COND_CS: cond_ex = c_f;
            COND_CC: cond_ex = ~c_f;
            COND_MI: cond_ex = n_f;
            COND_PL: cond_ex = ~n_f;
            COND_VS: cond_ex = v_f;
            COND_VC: cond_ex = ~v_f;
            COND_HI: cond_ex = c_f & ~z_f;
            COND_LS: cond_ex = ~c_f | z_f;
            COND_GE: cond_ex = (n_f == v_f);
            COND_LT: cond_ex = (n_f != v_f);
            COND_GT: cond_ex = ~z_f & (n_f == v_f);
            COND_LE: cond_ex = z_f | (n_f != v_f);
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    // The following instruction sees the new flags; there is no same-cycle bypass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags <= '0;
        end else begin
            if (flag_w[1] & cond_ex) begin
                flags[FLAG_N] <= alu_flags[FLAG_N];
                flags[FLAG_Z] <= alu_flags[FLAG_Z];
            end
            if (flag_w[0] & cond_ex) begin
                flags[FLAG_C] <= alu_flags[FLAG_C];
                flags[FLAG_V] <= alu_flags[FLAG_V];
            end
        end
    end

endmodule

// File: rtl/pipe_controller.sv
// Control unit for the 5-stage ARM-subset pipeline: decode, D->E->M->W control registers
// and branch resolution. Define PIPE_CTRL_PERF_EN to add exec/squash/flush counters.
module pipe_controller
    import pipe_ctrl_pkg::*;
`ifdef PIPE_CTRL_PERF_EN
#(
    parameter int CNT_W = 32
)
`endif
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] InstrD,
    input  logic [3:0]  ALUFlags,
    input  logic        FlushE,
    output logic [1:0]  RegSrcD,
    output logic [1:0]  ImmSrcD,
    output logic        ALUSrcE,
    output logic [1:0]  ALUControlE,
    output logic        BranchTakenE,
    output logic        MemtoRegE,
    output logic        MemWriteM,
    output logic        RegWriteM,
    output logic        RegWriteW,
    output logic        MemtoRegW,
    output logic        PCSrcW,
    output logic        PCWrPendingF
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] exec_cnt,
    output logic [CNT_W-1:0] squash_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    op_e        op_d;
    logic [5:0] funct_d;
    logic [3:0] cmd_d;
    logic       s_d;
    logic [3:0] rd_d;
    logic [1:0] reg_src_d;
    logic [1:0] imm_src_d;
    ctrl_e_t    ctrl_d;
    ctrl_e_t    ctrl_e;
    ctrl_mw_t   ctrl_m_next;
    ctrl_mw_t   ctrl_m;
    ctrl_mw_t   ctrl_w;
    logic       cond_ex;
    logic       unused_instr_bits;

    assign op_d    = op_e'(InstrD[27:26]);
    assign funct_d = InstrD[25:20];
    assign cmd_d   = funct_d[4:1];
    assign s_d     = funct_d[0];
    assign rd_d    = InstrD[15:12];

    // Register-number and offset fields are consumed by the datapath, not here.
    assign unused_instr_bits = ^{InstrD[19:16], InstrD[11:0]};

    always_comb begin
        ctrl_d      = '0;
        ctrl_d.cond = InstrD[31:28];
        reg_src_d   = 2'b00;
        imm_src_d   = IMM_ROT8;
        case (op_d)
            OP_DP: begin
                ctrl_d.alu_src = funct_d[5];
                case (cmd_d)
                    CMD_ADD: begin
                        ctrl_d.reg_w    = 1'b1;
                        ctrl_d.alu_ctrl = ALU_ADD;
                        ctrl_d.flag_w   = {s_d, s_d};
                    end
                    CMD_SUB: begin
                        ctrl_d.reg_w    = 1'b1;
                        ctrl_d.alu_ctrl = ALU_SUB;
                        ctrl_d.flag_w   = {s_d, s_d};
                    end
                    CMD_AND: begin
                        ctrl_d.reg_w    = 1'b1;
                        ctrl_d.alu_ctrl = ALU_AND;
                        ctrl_d.flag_w   = {s_d, 1'b0};
                    end
                    CMD_ORR: begin
                        ctrl_d.reg_w    = 1'b1;
                        ctrl_d.alu_ctrl = ALU_ORR;
                        ctrl_d.flag_w   = {s_d, 1'b0};
                    end
                    default: ;
                endcase
            end
            OP_MEM: begin
                ctrl_d.alu_src  = 1'b1;
                ctrl_d.alu_ctrl = ALU_ADD;
                imm_src_d       = IMM_12;
                if (funct_d[0]) begin
                    ctrl_d.reg_w      = 1'b1;
                    ctrl_d.mem_to_reg = 1'b1;
                end else begin
                    ctrl_d.mem_w = 1'b1;
                    reg_src_d    = 2'b10;
                end
            end
            OP_BR: begin
                ctrl_d.branch   = 1'b1;
                ctrl_d.alu_src  = 1'b1;
                ctrl_d.alu_ctrl = ALU_ADD;
                imm_src_d       = IMM_24;
                reg_src_d       = 2'b01;
            end
            default: ;
        endcase
        ctrl_d.pc_src = ctrl_d.reg_w & (rd_d == 4'hF);
    end

    // Decode outputs are forced low while reset is held so every output reads 0.
    assign RegSrcD = reset ? reg_src_d : 2'b00;
    assign ImmSrcD = reset ? imm_src_d : 2'b00;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_e <= '0;
        end else if (FlushE) begin
            ctrl_e <= '0;
        end else begin
            ctrl_e <= ctrl_d;
        end
    end

    cond_unit u_cond_unit (
        .clk       (clk),
        .rst_n     (reset),
        .cond      (ctrl_e.cond),
        .alu_flags (ALUFlags),
        .flag_w    (ctrl_e.flag_w),
        .cond_ex   (cond_ex)
    );

    assign ALUSrcE      = ctrl_e.alu_src;
    assign ALUControlE  = ctrl_e.alu_ctrl;
    assign MemtoRegE    = ctrl_e.mem_to_reg;
    assign BranchTakenE = ctrl_e.branch & cond_ex;

    always_comb begin
        ctrl_m_next            = '0;
        ctrl_m_next.reg_w      = ctrl_e.reg_w & cond_ex;
        ctrl_m_next.mem_w      = ctrl_e.mem_w & cond_ex;
        ctrl_m_next.mem_to_reg = ctrl_e.mem_to_reg;
        ctrl_m_next.pc_src     = ctrl_e.pc_src & cond_ex;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_m <= '0;
            ctrl_w <= '0;
        end else begin
            ctrl_m <= ctrl_m_next;
            ctrl_w <= ctrl_m;
        end
    end

    assign MemWriteM = ctrl_m.mem_w;
    assign RegWriteM = ctrl_m.reg_w;
    assign RegWriteW = ctrl_w.reg_w;
    assign MemtoRegW = ctrl_w.mem_to_reg;
    assign PCSrcW    = ctrl_w.pc_src;

    // The E-stage term is taken before its condition resolves, so fetch holds conservatively.
    assign PCWrPendingF = (reset & ctrl_d.pc_src) | ctrl_e.pc_src | ctrl_m.pc_src;

`ifdef PIPE_CTRL_PERF_EN
    logic valid_e;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_e    <= 1'b0;
            exec_cnt   <= '0;
            squash_cnt <= '0;
            flush_cnt  <= '0;
        end else begin
            valid_e <= ~FlushE;
            if (valid_e & cond_ex) begin
                exec_cnt <= exec_cnt + CNT_W'(1);
            end
            if (valid_e & ~cond_ex) begin
                squash_cnt <= squash_cnt + CNT_W'(1);
            end
            if (FlushE) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule
